// File: rtl/flu_issue_sched_pkg.sv
// Shared types for the FLU issue scheduler: functional-unit classes and division FSM states.
package flu_issue_sched_pkg;

    typedef enum logic [2:0] {
        FuAlu    = 3'd0,
        FuBranch = 3'd1,
        FuCsr    = 3'd2,
        FuMul    = 3'd3,
        FuDiv    = 3'd4
    } fu_class_t;

    localparam int unsigned MULT_LAT_DEFAULT = 1;

    typedef enum logic [0:0] {
        StIdle,
        StDivBusy
    } div_state_e;

endpackage

// File: rtl/flu_issue_sched_wb_slot_tracker.sv
// Reservation shift register for the shared FLU writeback port; bit 0 is the current cycle.
module flu_issue_sched_wb_slot_tracker #(
    parameter int unsigned Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             set_i,
    input  logic             shift_i,
    input  logic             clear_i,
    output logic [Depth-1:0] slot_o
);

    logic [Depth-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else begin
            if (shift_i) slot_d = slot_q >> 1;
            if (set_i)   slot_d[Depth-1] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) slot_q <= '0;
        else         slot_q <= slot_d;
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/flu_issue_sched.sv
// FLU issue scheduler: per-unit strobes, writeback-slot reservation for multiplies and
// serialisation of variable-latency divisions.
module flu_issue_sched
    import flu_issue_sched_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT,
    parameter int unsigned TID_W    = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                issue_valid_i,
    input  logic [2:0]          issue_class_i,
    input  logic [TID_W-1:0]    issue_tid_i,
    output logic                issue_ack_o,
    output logic                alu_valid_o,
    output logic                branch_valid_o,
    output logic                csr_valid_o,
    output logic                mult_valid_o,
    input  logic                csr_ready_i,
    input  logic                mult_ready_i,
    input  logic                mult_done_i,
    input  logic [TID_W-1:0]    mult_done_tid_i,
    output logic                div_busy_o,
    output logic [MULT_LAT-1:0] wb_slot_o
);

    div_state_e          state_q, state_d;
    logic [TID_W-1:0]    div_tid_q, div_tid_d;
    logic [MULT_LAT-1:0] slot_q;
    logic                ack;
    logic                is_mul, is_div;

    assign is_mul = (issue_class_i == FuMul);
    assign is_div = (issue_class_i == FuDiv);

    // rst_ni gates the ack so every output reads 0 while reset is held.
    always_comb begin
        ack = 1'b0;
        if (rst_ni && !flush_i && issue_valid_i && state_q == StIdle) begin
            case (issue_class_i)
                FuAlu, FuBranch: ack = ~slot_q[0];
                FuCsr:           ack = ~slot_q[0] & csr_ready_i;
                FuMul:           ack = mult_ready_i;
                FuDiv:           ack = mult_ready_i & (slot_q == '0);
                default:         ack = 1'b0;
            endcase
        end
    end

    assign issue_ack_o    = ack;
    assign alu_valid_o    = ack & (issue_class_i == FuAlu);
    assign branch_valid_o = ack & (issue_class_i == FuBranch);
    assign csr_valid_o    = ack & (issue_class_i == FuCsr);
    assign mult_valid_o   = ack & (is_mul | is_div);

    always_comb begin
        state_d   = state_q;
        div_tid_d = div_tid_q;
        if (flush_i) begin
            state_d   = StIdle;
            div_tid_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ack && is_div) begin
                        state_d   = StDivBusy;
                        div_tid_d = issue_tid_i;
                    end
                end
                StDivBusy: begin
                    // A done with another ID is an in-flight multiply, not our division.
                    if (mult_done_i && mult_done_tid_i == div_tid_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            div_tid_q <= '0;
        end else begin
            state_q   <= state_d;
            div_tid_q <= div_tid_d;
        end
    end

    assign div_busy_o = (state_q == StDivBusy);

    flu_issue_sched_wb_slot_tracker #(
        .Depth (MULT_LAT)
    ) u_wb_slot_tracker (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .set_i   (ack & is_mul),
        .shift_i (1'b1),
        .clear_i (flush_i),
        .slot_o  (slot_q)
    );

    assign wb_slot_o = slot_q;

endmodule

// File: tb/tb_flu_issue_sched.sv
// Directed bench: two scheduler instances (MULT_LAT 1 and 2) share stimulus; each scenario
// checks the instance whose latency it targets.
module tb_flu_issue_sched;
    import flu_issue_sched_pkg::*;

    localparam int unsigned TID_W = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             issue_valid_i;
    logic [2:0]       issue_class_i;
    logic [TID_W-1:0] issue_tid_i;
    logic             csr_ready_i;
    logic             mult_ready_i;
    logic             mult_done_i;
    logic [TID_W-1:0] mult_done_tid_i;

    logic       d1_ack, d1_alu, d1_br, d1_csr, d1_mul, d1_busy;
    logic [0:0] d1_wb;
    logic       d2_ack, d2_alu, d2_br, d2_csr, d2_mul, d2_busy;
    logic [1:0] d2_wb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    flu_issue_sched #(.MULT_LAT(1), .TID_W(TID_W)) u_dut1 (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .issue_valid_i   (issue_valid_i),
        .issue_class_i   (issue_class_i),
        .issue_tid_i     (issue_tid_i),
        .issue_ack_o     (d1_ack),
        .alu_valid_o     (d1_alu),
        .branch_valid_o  (d1_br),
        .csr_valid_o     (d1_csr),
        .mult_valid_o    (d1_mul),
        .csr_ready_i     (csr_ready_i),
        .mult_ready_i    (mult_ready_i),
        .mult_done_i     (mult_done_i),
        .mult_done_tid_i (mult_done_tid_i),
        .div_busy_o      (d1_busy),
        .wb_slot_o       (d1_wb)
    );

    flu_issue_sched #(.MULT_LAT(2), .TID_W(TID_W)) u_dut2 (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .issue_valid_i   (issue_valid_i),
        .issue_class_i   (issue_class_i),
        .issue_tid_i     (issue_tid_i),
        .issue_ack_o     (d2_ack),
        .alu_valid_o     (d2_alu),
        .branch_valid_o  (d2_br),
        .csr_valid_o     (d2_csr),
        .mult_valid_o    (d2_mul),
        .csr_ready_i     (csr_ready_i),
        .mult_ready_i    (mult_ready_i),
        .mult_done_i     (mult_done_i),
        .mult_done_tid_i (mult_done_tid_i),
        .div_busy_o      (d2_busy),
        .wb_slot_o       (d2_wb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else             n_pass++;
    endtask

    // Apply inputs mid-cycle, then let combinational outputs settle before checking.
    task automatic offer(input logic v, input logic [2:0] c, input logic [TID_W-1:0] t);
        issue_valid_i = v;
        issue_class_i = c;
        issue_tid_i   = t;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        csr_ready_i     = 1'b1;
        mult_ready_i    = 1'b1;
        mult_done_i     = 1'b0;
        mult_done_tid_i = '0;
        offer(1'b0, FuAlu, 3'd0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_wb1", d1_wb, 1'b0);
        check("rst_wb2", d2_wb, 2'b00);
        check("rst_busy", d1_busy, 1'b0);

        // Reset held with a valid ALU offer must not ack.
        rst_ni = 1'b0;
        offer(1'b1, FuAlu, 3'd0);
        check("rst_ack", d1_ack, 1'b0);
        check("rst_alu", d1_alu, 1'b0);
        next_cycle();
        rst_ni = 1'b1;

        // MULT_LAT=1: MUL occupies slot 0 of the following cycle.
        do_reset();
        offer(1'b1, FuMul, 3'd2);
        check("t1_mul_ack", d1_ack, 1'b1);
        check("t1_mul_strobe", d1_mul, 1'b1);
        next_cycle();
        offer(1'b1, FuAlu, 3'd3);
        check("t1_wb_busy", d1_wb, 1'b1);
        check("t1_alu_blocked", d1_ack, 1'b0);
        next_cycle();
        offer(1'b1, FuAlu, 3'd3);
        check("t1_alu_ack", d1_alu, 1'b1);
        next_cycle();

        // MULT_LAT=2: back-to-back multiplies.
        do_reset();
        offer(1'b1, FuMul, 3'd1);
        check("t2_ack0", d2_ack, 1'b1);
        next_cycle();
        offer(1'b1, FuMul, 3'd2);
        check("t2_wb_10", d2_wb, 2'b10);
        check("t2_ack1", d2_ack, 1'b1);
        next_cycle();
        offer(1'b0, FuAlu, 3'd0);
        check("t2_wb_11", d2_wb, 2'b11);
        next_cycle();
        check("t2_wb_01", d2_wb, 2'b01);
        offer(1'b1, FuBranch, 3'd0);
        check("t2_br_blocked", d2_ack, 1'b0);
        next_cycle();

        // Division blocks all issue until its own ID completes.
        do_reset();
        offer(1'b1, FuDiv, 3'd5);
        check("t3_div_ack", d1_mul, 1'b1);
        next_cycle();
        for (int i = 1; i <= 20; i++) begin
            mult_done_i     = (i == 10);
            mult_done_tid_i = 3'd3;
            offer(1'b1, (i % 2 == 0) ? FuMul : FuAlu, 3'd1);
            check("t3_blocked_ack", d1_ack, 1'b0);
            check("t3_busy", d1_busy, 1'b1);
            next_cycle();
        end
        mult_done_i     = 1'b1;
        mult_done_tid_i = 3'd5;
        offer(1'b1, FuAlu, 3'd1);
        check("t3_done_cycle_ack", d1_ack, 1'b0);
        next_cycle();
        mult_done_i = 1'b0;
        offer(1'b1, FuAlu, 3'd1);
        check("t3_idle", d1_busy, 1'b0);
        check("t3_alu_ack", d1_alu, 1'b1);
        check("t3_idle2", d2_busy, 1'b0);
        next_cycle();

        // MULT_LAT=2: DIV waits for pending multiply slots to drain.
        do_reset();
        offer(1'b1, FuMul, 3'd1);
        check("t4_mul_ack", d2_ack, 1'b1);
        next_cycle();
        offer(1'b1, FuDiv, 3'd2);
        check("t4_wb_10", d2_wb, 2'b10);
        check("t4_div_held1", d2_ack, 1'b0);
        next_cycle();
        offer(1'b1, FuDiv, 3'd2);
        check("t4_wb_01", d2_wb, 2'b01);
        check("t4_div_held2", d2_ack, 1'b0);
        next_cycle();
        offer(1'b1, FuDiv, 3'd2);
        check("t4_wb_00", d2_wb, 2'b00);
        check("t4_div_ack", d2_mul, 1'b1);
        next_cycle();
        check("t4_busy", d2_busy, 1'b1);

        // CSR waits on csr_ready; undefined class never acks.
        do_reset();
        csr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, FuCsr, 3'd4);
            check("t5_csr_held", d1_csr, 1'b0);
            next_cycle();
        end
        csr_ready_i = 1'b1;
        offer(1'b1, FuCsr, 3'd4);
        check("t5_csr_ack", d1_csr, 1'b1);
        check("t5_ack", d1_ack, 1'b1);
        next_cycle();
        offer(1'b1, 3'd5, 3'd4);
        check("t5_bad_class", d1_ack, 1'b0);
        next_cycle();
        mult_ready_i = 1'b0;
        offer(1'b1, FuMul, 3'd4);
        check("t5_mul_not_ready", d1_ack, 1'b0);
        next_cycle();
        mult_ready_i = 1'b1;

        // Flush: cancels division and reservations, suppresses same-cycle ack.
        do_reset();
        offer(1'b1, FuDiv, 3'd5);
        check("t6_div_ack", d1_ack, 1'b1);
        next_cycle();
        flush_i = 1'b1;
        offer(1'b1, FuAlu, 3'd0);
        check("t6_busy_pre", d1_busy, 1'b1);
        check("t6_flush_ack", d1_ack, 1'b0);
        next_cycle();
        flush_i = 1'b0;
        offer(1'b1, FuAlu, 3'd0);
        check("t6_busy_post", d1_busy, 1'b0);
        check("t6_alu_ack", d1_alu, 1'b1);
        next_cycle();
        offer(1'b1, FuMul, 3'd1);
        check("t6_mul_ack", d2_ack, 1'b1);
        next_cycle();
        offer(1'b0, FuAlu, 3'd0);
        next_cycle();
        flush_i = 1'b1;
        offer(1'b0, FuAlu, 3'd0);
        check("t6_wb_01", d2_wb, 2'b01);
        next_cycle();
        flush_i = 1'b0;
        offer(1'b1, FuAlu, 3'd0);
        check("t6_wb_cleared", d2_wb, 2'b00);
        check("t6_alu_ack2", d2_ack, 1'b1);
        next_cycle();
        flush_i = 1'b1;
        offer(1'b1, FuAlu, 3'd0);
        check("t6_flush_idle_ack", d1_ack, 1'b0);
        next_cycle();
        flush_i = 1'b0;

        // Reset mid-division; a stale completion afterwards is ignored.
        offer(1'b1, FuDiv, 3'd6);
        check("t6_div2_ack", d1_ack, 1'b1);
        next_cycle();
        offer(1'b1, FuAlu, 3'd0);
        check("t6_busy2", d1_busy, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_busy", d1_busy, 1'b0);
        check("t6_rst_ack", d1_ack, 1'b0);
        check("t6_rst_alu", d1_alu, 1'b0);
        check("t6_rst_wb", d2_wb, 2'b00);
        next_cycle();
        rst_ni          = 1'b1;
        mult_done_i     = 1'b1;
        mult_done_tid_i = 3'd6;
        offer(1'b1, FuAlu, 3'd0);
        check("t6_stale_ack", d1_ack, 1'b1);
        next_cycle();
        mult_done_i = 1'b0;
        offer(1'b0, FuAlu, 3'd0);
        check("t6_stale_busy", d1_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
